// File: rtl/csr_rmw_ctrl.sv
// csr_rmw_ctrl: read-modify-write sequencer in front of a shadow register.
// Arbitrates between the debug and core requesters. Debug has fixed priority.
// Each accepted request is executed in a single EXEC cycle. That cycle drives the
// masked new value and write strobe to the register. It also returns the
// pre-update value to the requester that issued the op.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   halted                     blocks acceptance of new core requests
//   core_valid/ready/op/wdata  core request channel (op: 00 RD 01 WR 10 SET 11 CLR)
//   core_rvalid/rdata          core response (one-cycle pulse, pre-update value)
//   dbg_*                      debug request/response channel, same layout as core_*
//   reg_value                  current shadow register value
//   reg_in, reg_write          next value and write strobe to the shadow register
//   busy                       high while an op executes
//
// State  | meaning
// IDLE   | ready for a request; debug wins over core
// EXEC   | latched op executes against reg_value; returns to IDLE
module csr_rmw_ctrl #(
  parameter int               Width     = 32,
  parameter logic [Width-1:0] WriteMask = {Width{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halted,
  input  logic             core_valid,
  output logic             core_ready,
  input  logic [1:0]       core_op,
  input  logic [Width-1:0] core_wdata,
  output logic             core_rvalid,
  output logic [Width-1:0] core_rdata,
  input  logic             dbg_valid,
  output logic             dbg_ready,
  input  logic [1:0]       dbg_op,
  input  logic [Width-1:0] dbg_wdata,
  output logic             dbg_rvalid,
  output logic [Width-1:0] dbg_rdata,
  input  logic [Width-1:0] reg_value,
  output logic [Width-1:0] reg_in,
  output logic             reg_write,
  output logic             busy
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [Width-1:0] wdata_q;
  logic             src_q;     // 1 = debug, 0 = core
  logic             accept;
  logic             accept_src;
  logic             exec;
  logic [Width-1:0] computed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      wdata_q <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q   <= accept_src;
        op_q    <= accept_src ? dbg_op    : core_op;
        wdata_q <= accept_src ? dbg_wdata : core_wdata;
      end
    end
  end

  // Every output is gated by rst_n so that an op caught mid-EXEC by reset
  // produces no response and no write.
  always_comb begin
    state_d    = state_q;
    core_ready = 1'b0;
    dbg_ready  = 1'b0;
    accept     = 1'b0;
    accept_src = 1'b0;
    exec       = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          dbg_ready  = 1'b1;
          core_ready = !dbg_valid && !halted;
          if (dbg_valid) begin
            accept     = 1'b1;
            accept_src = 1'b1;
          end else if (core_valid && core_ready) begin
            accept = 1'b1;
          end
          if (accept) state_d = EXEC;
        end
        EXEC: begin
          exec    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outside EXEC, and for READ, computed follows reg_value, so reg_in equals reg_value.
  always_comb begin
    computed = reg_value;
    if (exec) begin
      case (op_q)
        OP_WRITE: computed = wdata_q;
        OP_SET:   computed = reg_value | wdata_q;
        OP_CLEAR: computed = reg_value & ~wdata_q;
        default:  computed = reg_value;
      endcase
    end
  end

  assign reg_in      = (reg_value & ~WriteMask) | (computed & WriteMask);
  assign reg_write   = exec && ((op_q == OP_WRITE) ||
                                ((op_q != OP_READ) && (wdata_q != '0)));
  assign busy        = exec;
  assign core_rvalid = exec && !src_q;
  assign dbg_rvalid  = exec &&  src_q;
  assign core_rdata  = core_rvalid ? reg_value : '0;
  assign dbg_rdata   = dbg_rvalid  ? reg_value : '0;

endmodule

// File: doc/csr_rmw_ctrl.md
Name: csr_rmw_ctrl

Overview:
- Read-modify-write sequencer sitting directly upstream of a shadow register.
- Arbitrates CSR access requests from the core pipeline and from the debug module (abstract command path).
- Computes the new register value for WRITE/SET/CLEAR ops, applying a writable-bit mask.
- Drives the register's data input and write strobe, and returns the pre-update value to the requester.

Parameters:
- Width, 32, data width of the controlled register.
- WriteMask, 32'hFFFF_FFFF, bit i = 1 means bit i is software-writable; 0 bits always keep the current value.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- halted  input  1  hart in debug mode; core requests blocked while high.
- core_valid  input  1  core request valid.
- core_ready  output  1  core request accepted this cycle when valid and ready are both high.
- core_op  input  2  00 READ, 01 WRITE, 10 SET, 11 CLEAR.
- core_wdata  input  Width  operand.
- core_rvalid  output  1  one-cycle response pulse to core.
- core_rdata  output  Width  pre-update register value.
- dbg_valid, dbg_ready, dbg_op, dbg_wdata, dbg_rvalid, dbg_rdata  same directions, widths and meanings as core_*, for the debug requester.
- reg_value  input  Width  current register value (shadow register out).
- reg_in  output  Width  new value to shadow register in.
- reg_write  output  1  write strobe to shadow register.
- busy  output  1  high in EXEC.

Behaviour:
- FSM with two states: IDLE and EXEC.
- IDLE:
  - dbg_ready = 1.
  - core_ready = !dbg_valid && !halted.
  - Debug has fixed priority over core.
  - On an accepted handshake: latch op, wdata and source (1 bit), then go to EXEC next cycle.
  - No valid request accepted: stay in IDLE.
- EXEC (exactly one cycle, always returns to IDLE):
  - Both ready outputs = 0.
  - Only the latched source's rvalid = 1, and its rdata = reg_value sampled in this cycle.
  - Computed value: WRITE = wdata; SET = reg_value | wdata; CLEAR = reg_value & ~wdata.
  - reg_in = (reg_value & ~WriteMask) | (computed & WriteMask).
  - reg_write = 1 for WRITE.
  - reg_write = 1 for SET/CLEAR only when wdata != 0; SET/CLEAR with zero wdata are pure reads.
  - reg_write = 0 for READ; reg_in is then don't-care but must equal reg_value.
- Latency and throughput:
  - Handshake in cycle N gives rvalid and reg_write in cycle N+1.
  - The new value is visible on reg_value in cycle N+2.
  - Maximum throughput is one request per 2 cycles.
- Outputs outside EXEC: reg_write = 0, both rvalid = 0, rdata = 0.
- Simultaneous core_valid and dbg_valid in IDLE: debug is served; core stays pending (core_valid must be held by the requester) and is served on the next IDLE cycle if no debug request is present.
- halted rising while a core op is in EXEC: that op completes normally.
- halted only gates new acceptance.
- Requesters may change op/wdata after the handshake; the latched copies are used.
- Reset (rst_n low at a clock edge), including mid-EXEC:
  - Next state IDLE; latched op, wdata and source cleared.
  - The in-flight op is dropped: no rvalid, no reg_write.
  - During reset: readies = 0, rvalid = 0, reg_write = 0, busy = 0.
- reg_in/reg_write are combinational from latched state plus reg_value and must not depend on the *_valid inputs.

Test Plan:
- Reset then WRITE: reg_value = 0, core WRITE 32'hDEAD_BEEF → next cycle reg_write = 1, reg_in = 32'hDEAD_BEEF, core_rvalid = 1, core_rdata = 0; busy for 1 cycle.
- Masking with WriteMask = 32'h0000_00FF: reg_value = 32'h1234_5600, dbg WRITE 32'hFFFF_FFAB → reg_in = 32'h1234_56AB, dbg_rvalid = 1, core_rvalid = 0.
- SET/CLEAR:
  - reg_value = 32'h0000_00F0, core SET 32'h0F → reg_in = 32'hFF.
  - CLEAR 32'h30 on 32'hFF → reg_in = 32'hCF.
  - SET 0 → reg_write = 0, rdata = current value.
- Arbitration: core_valid and dbg_valid both high in one IDLE cycle → dbg accepted, core_ready = 0; core accepted 2 cycles later; each rvalid goes only to its own requester.
- Halt gating: halted = 1 with core_valid = 1 for 10 cycles → core_ready never asserted, reg_write = 0; dbg READ still completes.
- Reset mid-op: accept core WRITE, assert rst_n = 0 during EXEC → no further reg_write/rvalid after the edge; FSM in IDLE after release, and a fresh request completes normally.
